// File: rtl/counter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// counter_rr_scheduler
//
// Shares one WIDTH-bit incrementer among NUM_CH counter channels. Requests
// are served one at a time in round-robin order through a three-state FSM
// (IDLE -> GRANT -> ACK). One increment takes three cycles.
//
// Handshake (valid/ready style): req[i] acts as a level "valid" and is held
// by the requester. ack[i] is a one-cycle "done" pulse for channel i. Once a
// channel is latched in IDLE, its increment is committed; dropping req
// afterwards does not cancel it. A req bit still high in the IDLE cycle that
// follows ACK counts as a new request.
//
// Parameters:
//   NUM_CH  number of counter channels (>= 2)
//   WIDTH   bits per channel count (>= 1)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   req    [NUM_CH]        per-channel increment request (level)
//   clr    [NUM_CH]        per-channel synchronous clear of count and wrap flag
//   ack    [NUM_CH]        one-hot, one-cycle "increment committed" pulse
//   busy                   high while the FSM is in GRANT or ACK
//   q      [NUM_CH*WIDTH]  packed counts, channel i at [i*WIDTH +: WIDTH]
//   wrap   [NUM_CH]        sticky rollover flag per channel
//
// Build option:
//   COUNTER_SCHED_WRAP_FLAG_EN  when defined, builds the sticky wrap flags;
//                               otherwise wrap is tied to zero.
// -----------------------------------------------------------------------------
module counter_rr_scheduler #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       ack,
    output logic                    busy,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       wrap
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    sel;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    ptr_next;
    logic                any_req;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [NUM_CH-1:0]   sel_onehot;
    logic [NUM_CH-1:0]   write_en;
    logic [NUM_CH-1:0]   ack_next;
    logic                busy_next;

    logic [WIDTH-1:0]    cnt [NUM_CH];
    logic [WIDTH-1:0]    cur_cnt;
    logic [WIDTH-1:0]    inc_cnt;

    // -------------------------------------------------------------------------
    // Round-robin pick: rotate req so that bit 0 corresponds to ptr, find the
    // first set bit, then map the offset back to an absolute channel index.
    // -------------------------------------------------------------------------
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_CH];

    always_comb begin
        logic [PTR_W:0] idx;
        any_req = 1'b0;
        pick    = ptr;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_req && req_rot[k]) begin
                any_req = 1'b1;
                idx     = {1'b0, ptr} + (PTR_W+1)'(k);
                if (idx >= (PTR_W+1)'(NUM_CH)) begin
                    idx = idx - (PTR_W+1)'(NUM_CH);
                end
                pick = idx[PTR_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = GRANT;
            GRANT:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign sel_onehot = NUM_CH'(1) << sel;
    assign write_en   = (state == GRANT) ? sel_onehot : '0;

    // ack is registered from the GRANT cycle so it lands in the ACK cycle,
    // the same cycle the new count becomes visible.
    assign ack_next  = write_en;
    assign busy_next = (next_state != IDLE);

    assign ptr_next = (sel == PTR_W'(NUM_CH-1)) ? '0 : sel + PTR_W'(1);

    // -------------------------------------------------------------------------
    // Control registers: selection, pointer, ack and busy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= '0;
            ptr  <= '0;
            ack  <= '0;
            busy <= 1'b0;
        end else begin
            ack  <= ack_next;
            busy <= busy_next;
            if (state == IDLE && any_req) begin
                sel <= pick;
            end
            if (state == ACK) begin
                ptr <= ptr_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shared incrementer and per-channel count registers. clr outranks the
    // increment; only the selected channel is written during GRANT.
    // -------------------------------------------------------------------------
    assign cur_cnt = cnt[sel];
    assign inc_cnt = cur_cnt + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr[i]) begin
                    cnt[i] <= '0;
                end else if (write_en[i]) begin
                    cnt[i] <= inc_cnt;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign q[g*WIDTH +: WIDTH] = cnt[g];
    end

    // -------------------------------------------------------------------------
    // Sticky wrap flags
    // -------------------------------------------------------------------------
`ifdef COUNTER_SCHED_WRAP_FLAG_EN
    logic [NUM_CH-1:0] wrap_r;
    logic              rollover;

    // The increment rolls over exactly when the current count is all ones.
    assign rollover = &cur_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr[i]) begin
                    wrap_r[i] <= 1'b0;
                end else if (write_en[i] && rollover) begin
                    wrap_r[i] <= 1'b1;
                end
            end
        end
    end

    assign wrap = wrap_r;
`else
    assign wrap = '0;
`endif

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_rr_scheduler
//
// Directed and randomized stimulus for counter_rr_scheduler. Expected values
// come from a reference model kept as plain integer counts, flags and a
// round-robin pointer, updated transaction by transaction.
// -----------------------------------------------------------------------------
module tb_counter_rr_scheduler;

    localparam int NCH  = 2;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int MODV = 1 << W;
`ifdef COUNTER_SCHED_WRAP_FLAG_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   ack;
    logic             busy;
    logic [NCH*W-1:0] q;
    logic [NCH-1:0]   wrap;

    always #5 clk = ~clk;

    counter_rr_scheduler #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .clr   (clr),
        .ack   (ack),
        .busy  (busy),
        .q     (q),
        .wrap  (wrap)
    );

    // ---------------------------------------------------------------- model
    int checks = 0;
    int errors = 0;
    int mq [NCH];
    bit mw [NCH];
    int m_ptr;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c] = 0;
            mw[c] = 1'b0;
        end
        m_ptr = 0;
    endfunction

    // First requesting channel at or after the pointer, wrapping around.
    function automatic int model_pick(input logic [NCH-1:0] r);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH*W-1:0] exp_q();
        logic [NCH*W-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*W +: W] = W'(mq[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_wrap();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = mw[c];
        return v;
    endfunction

    function automatic void model_clear(input logic [NCH-1:0] m);
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                mq[c] = 0;
                mw[c] = 1'b0;
            end
        end
    endfunction

    // ---------------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".q"},    32'(q),    32'(exp_q()));
        check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap()));
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        clr   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One request/serve transaction starting from an IDLE cycle at a negedge.
    // clr_g is pulsed during the GRANT cycle; drop releases req during GRANT.
    task automatic serve(input logic [NCH-1:0] r, input logic [NCH-1:0] clr_g,
                         input bit drop, input string tag);
        int w;
        w   = model_pick(r);
        req = r;
        @(negedge clk);                         // GRANT
        check({tag, ".grant_busy"}, 32'(busy), 32'd1);
        check({tag, ".grant_ack"},  32'(ack),  32'd0);
        check_state({tag, ".grant"});
        if (drop) req = '0;
        clr = clr_g;
        @(negedge clk);                         // ACK
        for (int c = 0; c < NCH; c++) begin
            if (clr_g[c]) begin
                mq[c] = 0;
                mw[c] = 1'b0;
            end else if (c == w) begin
                if (mq[c] == MAXV && WRAP_EN) mw[c] = 1'b1;
                mq[c] = (mq[c] + 1) % MODV;
            end
        end
        m_ptr = (w + 1) % NCH;
        check({tag, ".ack"},      32'(ack),  32'(1) << w);
        check({tag, ".ack_busy"}, 32'(busy), 32'd1);
        check_state({tag, ".ackcyc"});
        clr = '0;
        req = '0;
        @(negedge clk);                         // IDLE
        check({tag, ".idle_ack"},  32'(ack),  32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic idle_cycle(input logic [NCH-1:0] m, input string tag);
        req = '0;
        clr = m;
        @(negedge clk);
        model_clear(m);
        check({tag, ".ack"},  32'(ack),  32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check_state(tag);
        clr = '0;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        do_reset();

        // Reset values
        check("rst.q",    32'(q),    32'd0);
        check("rst.ack",  32'(ack),  32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.wrap", 32'(wrap), 32'd0);

        // Single request on ch0
        serve(2'b01, 2'b00, 1'b0, "single");
        check("single.q0", 32'(q[3:0]), 32'd1);

        // Both channels requesting continuously for 12 cycles
        do_reset();
        req = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            logic [NCH-1:0] ea;
            @(negedge clk);
            ea = '0;
            if (c % 3 == 2) begin
                int ch;
                ch = model_pick(2'b11);
                ea[ch] = 1'b1;
                mq[ch] = (mq[ch] + 1) % MODV;
                m_ptr  = (ch + 1) % NCH;
            end
            check($sformatf("rr.c%0d.ack", c),  32'(ack),  32'(ea));
            check($sformatf("rr.c%0d.busy", c), 32'(busy), 32'((c % 3) != 0));
            check_state($sformatf("rr.c%0d", c));
        end
        req = '0;
        check("rr.final_q", 32'(q), 32'h22);

        // Sixteen increments on ch1 roll it over
        idle_cycle(2'b11, "wrap.pre_clr");
        for (int n = 0; n < 16; n++) serve(2'b10, 2'b00, 1'b0, $sformatf("wrap.n%0d", n));
        check("wrap.q1",   32'(q[7:4]),  32'd0);
        check("wrap.flag", 32'(wrap[1]), 32'(WRAP_EN));
        idle_cycle(2'b10, "wrap.clr");
        check("wrap.clr_flag", 32'(wrap[1]), 32'd0);

        // clr in the GRANT cycle of a ch0 increment from 5
        idle_cycle(2'b01, "clrg.pre");
        for (int n = 0; n < 5; n++) serve(2'b01, 2'b00, 1'b0, $sformatf("clrg.n%0d", n));
        check("clrg.q0_before", 32'(q[3:0]), 32'd5);
        serve(2'b01, 2'b01, 1'b0, "clrg.hit");
        check("clrg.q0_after", 32'(q[3:0]), 32'd0);

        // Reset asserted in GRANT with q0 = 7
        do_reset();
        for (int n = 0; n < 7; n++) serve(2'b01, 2'b00, 1'b0, $sformatf("rstg.n%0d", n));
        req = 2'b01;
        @(negedge clk);
        check("rstg.in_grant", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstg.q",    32'(q),    32'd0);
        check("rstg.ack",  32'(ack),  32'd0);
        check("rstg.busy", 32'(busy), 32'd0);
        check("rstg.wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("rstg.post%0d.ack", n), 32'(ack), 32'd0);
            check_state($sformatf("rstg.post%0d", n));
        end

        // req dropped during GRANT: increment completes, pointer moves on
        serve(2'b01, 2'b00, 1'b1, "drop");
        check("drop.q0", 32'(q[3:0]), 32'd1);
        serve(2'b11, 2'b00, 1'b0, "drop.next");
        check("drop.next_q1", 32'(q[7:4]), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(NCH'($urandom_range(0, (1 << NCH) - 1)), $sformatf("rnd%0d.idle", n));
            end else begin
                logic [NCH-1:0] r;
                logic [NCH-1:0] cm;
                r  = NCH'($urandom_range(1, (1 << NCH) - 1));
                cm = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
                serve(r, cm, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
